branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor for the pipeline. It looks up the PF-stage PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and returns the predicted next PC one cycle later. This value is the `target_addr_final` that the next-PC selector checks against the resolved address. The predictor receives each resolved control-transfer instruction back from the pipeline, using the same NPCOp encoding, and trains its table from it.

## Interface
Parameters:
- `ENTRIES`, 16: BTB entries; power of two, 4..256.
- `RAS_DEPTH`, 4: return-address-stack depth; power of two. Only used with RAS compiled in.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  1  lookup strobe. Low means PF is stalled: outputs hold.
- `PC_PF`  in  32  PC being looked up.
- `flush`  in  1  `Instr_Flush` from the next-PC selector. Squashes the pending prediction.
- `upd_valid`  in  1  a resolved instruction is presented this cycle.
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_op`  in  2  NPCOp: 00 sequential, 01 branch, 10 jump, 11 jump-return.
- `upd_taken`  in  1  resolved direction.
- `upd_target`  in  32  resolved target.
- `upd_call`  in  1  the instruction links (jal/jalr/bal).
- `pred_valid`  out  1  the prediction outputs are meaningful.
- `pred_hit`  out  1  BTB tag hit.
- `pred_taken`  out  1  predicted taken.
- `target_addr_final`  out  32  predicted next PC.

## Operation
- Index is `PC[log2(ENTRIES)+1:2]`. Tag is `PC[31:log2(ENTRIES)+2]`.
- Each entry holds: valid, tag, op (2 bits), target (32 bits), ctr (2 bits).
- Lookup is registered. When `req` is high, the outputs for `PC_PF` appear the next cycle.
  - On hit, taken is: op 01 → `ctr[1]`; op 10 and op 11 → 1.
  - `target_addr_final` = taken ? entry target : `PC_PF + 4`.
  - On miss, hit = 0, taken = 0 and `target_addr_final` = `PC_PF + 4`.
- `flush` high forces `pred_valid` to 0 on the next edge, even if `req` is high that cycle.
- Update applies only when `upd_valid` is high and `upd_op` != 00. Op-00 updates are ignored.
  - **Tag miss:** allocate or overwrite the entry with valid = 1, the new tag, op, and `upd_target`. Set ctr = `upd_taken` ? 10 : 01.
  - **Tag hit:** rewrite target and op. For op 01, ctr increments if taken and decrements if not, saturating at 11 and 00. For other ops, ctr is left unchanged.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents (read-before-write). The update still commits.
- All arithmetic is modulo 2^32. `PC + 4` wraps from `FFFFFFFC` to `00000000`.

## Timing
- Lookup latency is exactly 1 cycle. Update latency is 1 cycle: an update in cycle N is visible to a lookup issued in cycle N+1.
- With `req` low and `flush` low, all outputs hold their values.
- Reset (async, any time, including mid-update):
  - every entry becomes valid = 0 and ctr = 01;
  - `pred_valid`, `pred_hit` and `pred_taken` become 0;
  - `target_addr_final` becomes `32'h0`;
  - RAS count becomes 0.
  - Updates in flight are discarded.
- There is no backpressure on the update port: one update is accepted per cycle.

## Configuration
- `BP_RAS_EN` defined:
  - A RAS of `RAS_DEPTH` entries is instantiated.
  - An update with `upd_call` = 1 pushes `upd_pc + 8` (delay-slot return). A push when full overwrites the oldest entry and the count stays at `RAS_DEPTH`.
  - An op-11 update pops; a pop when empty is a no-op.
  - A push and a pop in the same update, such as jalr used as a return: pop first, then push.
  - A hit on an op-11 entry predicts the RAS top when the count is greater than 0, otherwise the stored target.
- `BP_RAS_EN` undefined: there is no RAS, `upd_call` is ignored, and op-11 entries predict the stored target.

## Structure
- Package `bp_pkg`:
  - NPCOp constants `NPC_SEQ`, `NPC_BR`, `NPC_J`, `NPC_JR`;
  - counter constants `CTR_WNT` = 01 and `CTR_WT` = 10;
  - the BTB entry struct typedef.
- Sub-module `bp_ras` holds the stack with push, pop, top and count. It is instantiated only under `BP_RAS_EN`.

## Test plan
- **Cold miss:** reset, `req` with `PC_PF` = `BFC00100` → next cycle `pred_valid` = 1, hit = 0, taken = 0, `target_addr_final` = `BFC00104`.
- **Train branch:**
  - update op 01, pc `80000010`, taken, target `80000040`, then look up `80000010` → hit, ctr 10, taken, target `80000040`.
  - Two not-taken updates → ctr 00, `target_addr_final` = `80000014`.
  - A further not-taken update leaves ctr at 00.
- **Aliasing:** with ENTRIES = 16, train `80000010`, then update `80000410` as op 10 → a lookup of `80000010` misses, and a lookup of `80000410` gives taken and the new target.
- **Same-cycle conflict and flush:** an update and a lookup to the same index in one cycle → the lookup returns old data. Then `flush` together with `req` → `pred_valid` = 0 on the next cycle.
- **RAS (`BP_RAS_EN`):**
  - call update at pc `80000020` pushes `80000028`; an op-11 entry hit predicts `80000028`.
  - Five pushes with depth 4 drop the oldest.
  - A pop on empty leaves the count at 0 and prediction falls back to the stored target.
- **Async reset:** assert `rst` mid-cycle during an update → outputs are 0 immediately, and a subsequent lookup of a previously trained PC misses.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the fetch-side branch predictor.
//   NPC_*      : NPCOp encoding shared with the next-PC selector.
//   CTR_*      : 2-bit saturating counter initial values.
//   btb_entry_t: one BTB entry (valid, tag, op, target, ctr).
//   ctr_step() : saturating counter update.
package bp_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;

  // Widest tag over the legal ENTRIES range (ENTRIES >= 4 leaves PC[31:4]).
  // Narrower configurations zero-extend their tag into this field.
  localparam int unsigned TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [1:0]           op;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_RESET = '{
    valid:  1'b0,
    tag:    '0,
    op:     NPC_SEQ,
    target: '0,
    ctr:    CTR_WNT
  };

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack.
//   clk, rst     : clock, asynchronous active-high reset (count cleared).
//   push_i       : push push_data_i; when full the oldest entry is overwritten.
//   pop_i        : pop the top entry; ignored when empty.
//   push_data_i  : return address to push.
//   top_o        : current top of stack (meaningful only when count_o > 0).
//   count_o      : number of valid entries, 0..Depth.
// A simultaneous push and pop pops first, then pushes.
// Depth must be a power of two (>= 2) so the pointer wraps naturally.
module bp_ras #(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [31:0]            push_data_i,
  output logic [31:0]            top_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [31:0]     stack_q [Depth];
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != '0) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
    if (push_i) begin
      top_d = top_d + PtrW'(1);
      if (cnt_d != CntW'(Depth)) begin
        cnt_d = cnt_d + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (push_i) begin
        stack_q[top_d] <= push_data_i;
      end
    end
  end

  assign top_o   = stack_q[top_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, registered lookup.
//   clk, rst           : clock, asynchronous active-high reset.
//   req, PC_PF         : lookup strobe and PC; result appears next cycle.
//   flush              : squash the pending prediction (pred_valid -> 0).
//   upd_*              : resolved control transfer used for training.
//   pred_valid/hit/taken, target_addr_final : registered prediction.
// Optional feature: define BP_RAS_EN to add a return-address stack for
// op-11 (jump-return) predictions and upd_call pushes.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] PC_PF,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_op,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_call,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] target_addr_final
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];

  logic                 pred_valid_q, pred_hit_q, pred_taken_q;
  logic [31:0]          target_q;

  logic [IdxW-1:0]      lk_idx, up_idx;
  logic [TAG_MAX_W-1:0] lk_tag, up_tag;
  logic                 lk_hit, lk_taken, up_hit, upd_en;
  logic [31:0]          lk_target, lk_jump_target;
  btb_entry_t           up_new;

  logic [31:0]          ras_top;
  logic                 ras_nonempty;

  assign lk_idx = PC_PF[IdxW+1:2];
  assign lk_tag = TAG_MAX_W'(PC_PF[31:IdxW+2]);
  assign up_idx = upd_pc[IdxW+1:2];
  assign up_tag = TAG_MAX_W'(upd_pc[31:IdxW+2]);

  // Lookup reads the table as it stands before this cycle's update commits.
  assign lk_hit = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);

  always_comb begin
    lk_taken = 1'b0;
    if (lk_hit) begin
      case (btb_q[lk_idx].op)
        NPC_BR:        lk_taken = btb_q[lk_idx].ctr[1];
        NPC_J, NPC_JR: lk_taken = 1'b1;
        default:       lk_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    lk_jump_target = btb_q[lk_idx].target;
    if (btb_q[lk_idx].op == NPC_JR && ras_nonempty) begin
      lk_jump_target = ras_top;
    end
    lk_target = lk_taken ? lk_jump_target : (PC_PF + 32'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      target_q     <= '0;
    end else begin
      if (flush) begin
        pred_valid_q <= 1'b0;
      end else if (req) begin
        pred_valid_q <= 1'b1;
      end
      if (req) begin
        pred_hit_q   <= lk_hit;
        pred_taken_q <= lk_taken;
        target_q     <= lk_target;
      end
    end
  end

  assign pred_valid        = pred_valid_q;
  assign pred_hit          = pred_hit_q;
  assign pred_taken        = pred_taken_q;
  assign target_addr_final = target_q;

  // Training.
  assign upd_en = upd_valid && (upd_op != NPC_SEQ);
  assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);

  always_comb begin
    up_new        = BTB_RESET;
    up_new.valid  = 1'b1;
    up_new.tag    = up_tag;
    up_new.op     = upd_op;
    up_new.target = upd_target;
    if (!up_hit) begin
      up_new.ctr = upd_taken ? CTR_WT : CTR_WNT;
    end else if (upd_op == NPC_BR) begin
      up_new.ctr = ctr_step(btb_q[up_idx].ctr, upd_taken);
    end else begin
      up_new.ctr = btb_q[up_idx].ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i] <= BTB_RESET;
      end
    end else if (upd_en) begin
      btb_q[up_idx] <= up_new;
    end
  end

`ifdef BP_RAS_EN
  logic                      ras_push, ras_pop;
  logic [31:0]               ras_push_data;
  logic [$clog2(RAS_DEPTH):0] ras_count;

  assign ras_push      = upd_en && upd_call;
  assign ras_pop       = upd_en && (upd_op == NPC_JR);
  assign ras_push_data = upd_pc + 32'd8;  // return past the delay slot

  bp_ras #(
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (ras_push_data),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

  assign ras_nonempty = (ras_count != '0);
`else
  logic unused_upd;
  assign unused_upd   = ^{upd_call, upd_pc[1:0]};
  assign ras_top      = '0;
  assign ras_nonempty = 1'b0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor.
// Covers both builds; RAS scenarios run only when BP_RAS_EN is defined.
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, flush, upd_valid, upd_taken, upd_call;
  logic [31:0] PC_PF, upd_pc, upd_target;
  logic [1:0]  upd_op;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] target_addr_final;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES   (16),
    .RAS_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .PC_PF             (PC_PF),
    .flush             (flush),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_op            (upd_op),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .upd_call          (upd_call),
    .pred_valid        (pred_valid),
    .pred_hit          (pred_hit),
    .pred_taken        (pred_taken),
    .target_addr_final (target_addr_final)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic v, input logic h, input logic t,
                            input logic [31:0] tgt);
    check_eq({tag, "/valid"},  {31'b0, pred_valid}, {31'b0, v});
    check_eq({tag, "/hit"},    {31'b0, pred_hit},   {31'b0, h});
    check_eq({tag, "/taken"},  {31'b0, pred_taken}, {31'b0, t});
    check_eq({tag, "/target"}, target_addr_final,   tgt);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    req   = 1'b1;
    PC_PF = pc;
    tick();
    req   = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [1:0] op, input logic tk,
                        input logic [31:0] tgt, input logic call);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_op     = op;
    upd_taken  = tk;
    upd_target = tgt;
    upd_call   = call;
    tick();
    upd_valid  = 1'b0;
    upd_call   = 1'b0;
  endtask

`ifdef BP_RAS_EN
  logic [31:0] exp_pop [4];
`endif

  initial begin
    rst        = 1'b1;
    req        = 1'b0;
    flush      = 1'b0;
    upd_valid  = 1'b0;
    upd_taken  = 1'b0;
    upd_call   = 1'b0;
    upd_op     = NPC_SEQ;
    PC_PF      = '0;
    upd_pc     = '0;
    upd_target = '0;

    tick();
    check_pred("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Cold miss and sequential wrap.
    lookup(32'hBFC0_0100);
    check_pred("cold", 1'b1, 1'b0, 1'b0, 32'hBFC0_0104);
    PC_PF = 32'h1234_5678;
    tick();
    check_pred("hold", 1'b1, 1'b0, 1'b0, 32'hBFC0_0104);
    lookup(32'hFFFF_FFFC);
    check_pred("wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0000);

    // Branch training: alloc taken -> 10.
    update(32'h8000_0010, NPC_BR, 1'b1, 32'h8000_0040, 1'b0);
    lookup(32'h8000_0010);
    check_pred("br_alloc", 1'b1, 1'b1, 1'b1, 32'h8000_0040);
    update(32'h8000_0010, NPC_BR, 1'b0, 32'h8000_0040, 1'b0);  // 01
    update(32'h8000_0010, NPC_BR, 1'b0, 32'h8000_0040, 1'b0);  // 00
    lookup(32'h8000_0010);
    check_pred("br_nt2", 1'b1, 1'b1, 1'b0, 32'h8000_0014);
    update(32'h8000_0010, NPC_BR, 1'b0, 32'h8000_0040, 1'b0);  // stays 00
    update(32'h8000_0010, NPC_BR, 1'b1, 32'h8000_0040, 1'b0);  // 01
    lookup(32'h8000_0010);
    check_pred("br_sat_lo", 1'b1, 1'b1, 1'b0, 32'h8000_0014);
    update(32'h8000_0010, NPC_BR, 1'b1, 32'h8000_0040, 1'b0);  // 10
    lookup(32'h8000_0010);
    check_pred("br_retaken", 1'b1, 1'b1, 1'b1, 32'h8000_0040);
    update(32'h8000_0010, NPC_BR, 1'b1, 32'h8000_0040, 1'b0);  // 11
    update(32'h8000_0010, NPC_BR, 1'b1, 32'h8000_0040, 1'b0);  // stays 11
    update(32'h8000_0010, NPC_BR, 1'b0, 32'h8000_0040, 1'b0);  // 10
    lookup(32'h8000_0010);
    check_pred("br_sat_hi", 1'b1, 1'b1, 1'b1, 32'h8000_0040);

    // Aliasing on index 4.
    update(32'h8000_0410, NPC_J, 1'b1, 32'h8000_1000, 1'b0);
    lookup(32'h8000_0010);
    check_pred("alias_old", 1'b1, 1'b0, 1'b0, 32'h8000_0014);
    lookup(32'h8000_0410);
    check_pred("alias_new", 1'b1, 1'b1, 1'b1, 32'h8000_1000);

    // Same-cycle lookup and update: read-before-write.
    req   = 1'b1;
    PC_PF = 32'h8000_0410;
    update(32'h8000_0410, NPC_J, 1'b1, 32'h8000_2000, 1'b0);
    req   = 1'b0;
    check_pred("rbw_old", 1'b1, 1'b1, 1'b1, 32'h8000_1000);
    lookup(32'h8000_0410);
    check_pred("rbw_new", 1'b1, 1'b1, 1'b1, 32'h8000_2000);

    // Flush wins over req, and the squash holds while idle.
    req   = 1'b1;
    flush = 1'b1;
    tick();
    req   = 1'b0;
    flush = 1'b0;
    check_eq("flush_valid", {31'b0, pred_valid}, 32'd0);
    tick();
    check_eq("flush_hold", {31'b0, pred_valid}, 32'd0);

    // Op-00 updates are ignored.
    update(32'h8000_0020, NPC_SEQ, 1'b1, 32'h8000_9000, 1'b0);
    lookup(32'h8000_0020);
    check_pred("seq_ignored", 1'b1, 1'b0, 1'b0, 32'h8000_0024);

    // Jump-return with an empty (or absent) RAS uses the stored target.
    update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b0);
    lookup(32'h8000_0030);
    check_pred("jr_stored", 1'b1, 1'b1, 1'b1, 32'h8000_0100);

`ifdef BP_RAS_EN
    update(32'h8000_0020, NPC_J, 1'b1, 32'h8000_0200, 1'b1);  // push 80000028
    lookup(32'h8000_0030);
    check_pred("ras_call", 1'b1, 1'b1, 1'b1, 32'h8000_0028);
    update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b0);  // pop -> empty
    lookup(32'h8000_0030);
    check_eq("ras_pop_empty", target_addr_final, 32'h8000_0100);
    update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b0);  // pop on empty
    lookup(32'h8000_0030);
    check_eq("ras_pop_noop", target_addr_final, 32'h8000_0100);

    // Five pushes into a depth-4 stack drop 80000108.
    for (int i = 1; i <= 5; i++) begin
      update(32'h8000_0000 + (32'(i) << 8), NPC_J, 1'b1, 32'h8000_0800, 1'b1);
    end
    lookup(32'h8000_0030);
    check_eq("ras_full_top", target_addr_final, 32'h8000_0508);
    exp_pop[0] = 32'h8000_0408;
    exp_pop[1] = 32'h8000_0308;
    exp_pop[2] = 32'h8000_0208;
    exp_pop[3] = 32'h8000_0100;  // empty again: stored target
    for (int i = 0; i < 4; i++) begin
      update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b0);
      lookup(32'h8000_0030);
      check_eq($sformatf("ras_drain%0d", i), target_addr_final, exp_pop[i]);
    end

    // jalr acting as return and call: pop, then push.
    update(32'h8000_0600, NPC_J, 1'b1, 32'h8000_0800, 1'b1);   // push 80000608
    update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b1);  // pop 608, push 38
    lookup(32'h8000_0030);
    check_eq("ras_poppush", target_addr_final, 32'h8000_0038);
    update(32'h8000_0030, NPC_JR, 1'b1, 32'h8000_0100, 1'b0);
    lookup(32'h8000_0030);
    check_eq("ras_poppush_pop", target_addr_final, 32'h8000_0100);
`else
    update(32'h8000_0020, NPC_J, 1'b1, 32'h8000_0200, 1'b1);  // upd_call ignored
    lookup(32'h8000_0030);
    check_pred("jr_noras", 1'b1, 1'b1, 1'b1, 32'h8000_0100);
`endif

    // Asynchronous reset in the middle of an update.
    lookup(32'h8000_0410);
    check_pred("pre_rst", 1'b1, 1'b1, 1'b1, 32'h8000_2000);
    req        = 1'b1;
    PC_PF      = 32'h8000_0410;
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_0010;
    upd_op     = NPC_BR;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_ABCD;
    #2;
    rst = 1'b1;
    #1;
    check_pred("rst_async", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    upd_valid = 1'b0;
    req       = 1'b0;
    lookup(32'h8000_0410);
    check_pred("rst_trained", 1'b1, 1'b0, 1'b0, 32'h8000_0414);
    lookup(32'h8000_0010);
    check_pred("rst_inflight", 1'b1, 1'b0, 1'b0, 32'h8000_0014);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
